axi2mem_synch_resp: RTL and testbench
=====================================

# axi2mem_synch_resp

Write-response stage of the axi2mem bridge, sitting directly downstream of the TCDM synch combiner. It accepts joined synch events (transaction ID) once both TCDM halves of a transaction are complete, queues them, and returns them as ID-tagged responses over a valid/ready handshake toward the AXI response channel. It also counts outstanding transactions, from command acceptance to response delivery, and raises a busy flag for the cluster idle logic.

## Interface
- ID_WIDTH, 6, width of synch/response ID
- FIFO_DEPTH, 4, response queue depth (power of two, >=2)
- CNT_WIDTH, 8, outstanding-transaction counter width
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- trans_req_i  in  1  new transaction accepted by command stage
- trans_gnt_o  out  1  counter can accept a transaction (not saturated)
- synch_req_i  in  1  joined synch event valid
- synch_id_i  in  ID_WIDTH  ID of completed transaction
- synch_gnt_o  out  1  synch event accepted this cycle
- resp_valid_o  out  1  response available
- resp_id_o  out  ID_WIDTH  response ID (queue head)
- resp_ready_i  in  1  response consumer ready
- busy_o  out  1  outstanding count nonzero
- outstanding_o  out  CNT_WIDTH  current outstanding count
- err_o  out  1  sticky protocol error (see Configuration)

## Operation
- Queue: circular FIFO, FIFO_DEPTH entries of ID_WIDTH; read/write pointers log2(FIFO_DEPTH) bits wrapping modulo depth; occupancy counter log2(FIFO_DEPTH)+1 bits.
- synch_gnt_o = !full. No same-cycle pop credit: a full queue refuses a push even when a pop happens in the same cycle.
- Push on synch_req_i && synch_gnt_o; the ID is written at the write pointer.
- resp_valid_o = !empty. resp_id_o = entry at the read pointer. No fall-through.
- Pop on resp_valid_o && resp_ready_i.
- Push and pop together when not full and not empty: occupancy unchanged, both pointers advance.
- Outstanding counter:
  - trans_gnt_o = (count != 2^CNT_WIDTH-1).
  - Increment on trans_req_i && trans_gnt_o.
  - Decrement on pop.
  - Increment and decrement together: count unchanged.
- busy_o = (count != 0).
- Pop with count == 0 is an underflow. The counter holds at 0 and never wraps.
- While rst_ni is low, trans_gnt_o and synch_gnt_o are forced to 0.

## Timing
- Reset values (at the first clock edge with rst_ni low):
  - pointers, occupancy and count = 0
  - resp_valid_o = 0, resp_id_o = 0, busy_o = 0, outstanding_o = 0, err_o = 0
- After reset release, synch_gnt_o = 1 and trans_gnt_o = 1.
- Latency: synch accepted at edge N gives resp_valid_o = 1 and resp_id_o = ID in the cycle after edge N (1 cycle).
- Back-to-back responses at 1 per cycle when resp_ready_i is held high.
- resp_id_o stays stable while resp_valid_o = 1 and resp_ready_i = 0.
- outstanding_o and busy_o update one edge after the triggering handshake.
- Reset asserted mid-operation: queued responses are discarded and the count is cleared on that edge. No response is issued for them.

## Configuration
- AXI2MEM_SYNCH_RESP_ERR_CHK_EN defined:
  - err_o sets on an underflow pop.
  - err_o also sets on a synch_req_i that arrives while the queue is full, so is not granted.
  - err_o is sticky until reset.
- Not defined:
  - err_o is tied to 0.
  - No detection logic is compiled in.
  - Underflow still holds the count at 0.

## Test plan
- Reset release, then trans_req_i pulsed 3 times, then synch IDs 0x05, 0x2A, 0x3F with resp_ready_i=1 -> responses 0x05, 0x2A, 0x3F in order, 1 cycle after each push; outstanding_o goes 3->0; busy_o falls after the last pop.
- resp_ready_i=0, 5 synch events with FIFO_DEPTH=4 -> synch_gnt_o=0 after the 4th push; 5th not accepted; err_o=1 with macro, 0 without; then ready=1 -> 4 responses drain, gnt returns.
- Simultaneous trans_req_i and response pop with count=2 -> count stays 2; simultaneous push and pop with occupancy 2 -> occupancy stays 2 and pointers wrap correctly across depth.
- Counter saturation with CNT_WIDTH=2 -> after 3 increments trans_gnt_o=0; a 4th trans_req_i is ignored; one pop -> count 2, trans_gnt_o=1.
- Pop with count 0 (synch without prior trans_req_i) -> count stays 0; err_o=1 only with macro.
- Assert rst_ni low with 2 queued responses and count 3 -> next edge: resp_valid_o=0, outstanding_o=0, err_o=0; gnts low until release.

Source files
------------

// File: rtl/axi2mem_synch_resp.sv
// axi2mem_synch_resp: queues joined TCDM synch IDs as AXI write responses and tracks outstanding transactions.
// Optional error detection is compiled in with `define AXI2MEM_SYNCH_RESP_ERR_CHK_EN.
module axi2mem_synch_resp #(
    parameter int ID_WIDTH   = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 trans_req_i,
    output logic                 trans_gnt_o,
    input  logic                 synch_req_i,
    input  logic [ID_WIDTH-1:0]  synch_id_i,
    output logic                 synch_gnt_o,
    output logic                 resp_valid_o,
    output logic [ID_WIDTH-1:0]  resp_id_o,
    input  logic                 resp_ready_i,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] outstanding_o,
    output logic                 err_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0]        PTR_ONE  = 1;
    localparam logic [PW:0]          OCC_ONE  = 1;
    localparam logic [PW:0]          OCC_FULL = FIFO_DEPTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

    logic [ID_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          occ;
    logic [CNT_WIDTH-1:0] count;
    logic                 full, empty, push, pop, inc;

    assign full          = occ == OCC_FULL;
    assign empty         = occ == '0;
    assign synch_gnt_o   = rst_ni && !full;
    assign trans_gnt_o   = rst_ni && (count != '1);
    assign push          = synch_req_i && synch_gnt_o;
    assign resp_valid_o  = !empty;
    assign pop           = resp_valid_o && resp_ready_i;
    assign inc           = trans_req_i && trans_gnt_o;
    assign resp_id_o     = empty ? '0 : mem[rd_ptr];
    assign busy_o        = count != '0;
    assign outstanding_o = count;

    // Queue storage: written at the write pointer on every accepted synch event
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= synch_id_i;
    end

    // Queue pointers and occupancy; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop) occ <= occ + OCC_ONE;
            else if (pop && !push) occ <= occ - OCC_ONE;
        end
    end

    // Outstanding counter: saturates via trans_gnt_o at the top, holds at zero on underflow pops
    always_ff @(posedge clk_i) begin
        if (!rst_ni) count <= '0;
        else if (inc && !pop) count <= count + CNT_ONE;
        else if (pop && !inc && count != '0) count <= count - CNT_ONE;
    end

`ifdef AXI2MEM_SYNCH_RESP_ERR_CHK_EN
    logic err_q;
    assign err_o = err_q;

    // Sticky error on an underflow pop or a synch event refused by a full queue
    always_ff @(posedge clk_i) begin
        if (!rst_ni) err_q <= 1'b0;
        else if ((pop && count == '0) || (synch_req_i && full)) err_q <= 1'b1;
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi2mem_synch_resp.sv
// tb_axi2mem_synch_resp: directed scoreboard bench for axi2mem_synch_resp (ID 6, depth 4, counter width 2).
module tb_axi2mem_synch_resp;
    localparam int IW = 6;
    localparam int CW = 2;
`ifdef AXI2MEM_SYNCH_RESP_ERR_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trans_req, trans_gnt, synch_req, synch_gnt;
    logic [IW-1:0] synch_id, resp_id;
    logic          resp_valid, resp_ready, busy, err;
    logic [CW-1:0] outstanding;

    int checks = 0;
    int errors = 0;
    logic [IW-1:0] exp_q[$];

    axi2mem_synch_resp #(.ID_WIDTH(IW), .FIFO_DEPTH(4), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .trans_req_i(trans_req), .trans_gnt_o(trans_gnt),
        .synch_req_i(synch_req), .synch_id_i(synch_id), .synch_gnt_o(synch_gnt),
        .resp_valid_o(resp_valid), .resp_id_o(resp_id), .resp_ready_i(resp_ready),
        .busy_o(busy), .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_id(input logic [IW-1:0] id);
        synch_req = 1'b1;
        synch_id  = id;
        exp_q.push_back(id);
    endtask

    // Monitor: every response handshake is compared against the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) chk("unexpected_resp", resp_id, 32'hDEAD);
            else chk("resp_id", resp_id, exp_q.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0; trans_req = 1'b0; synch_req = 1'b0; synch_id = '0; resp_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", resp_valid, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_synch_gnt", synch_gnt, 0);
        chk("rst_trans_gnt", trans_gnt, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_synch_gnt", synch_gnt, 1);
        chk("rel_trans_gnt", trans_gnt, 1);

        // Three transactions saturate the 2-bit counter; a fourth is ignored
        trans_req = 1'b1;
        tick(); tick(); tick();
        chk("sat_outstanding", outstanding, 3);
        chk("sat_trans_gnt", trans_gnt, 0);
        chk("sat_busy", busy, 1);
        tick();
        trans_req = 1'b0;
        chk("sat_ignored", outstanding, 3);

        // In-order responses, one cycle latency, back to back
        resp_ready = 1'b1;
        push_id(6'h05);
        tick();
        chk("lat_valid", resp_valid, 1);
        chk("lat_id", resp_id, 6'h05);
        chk("cnt_after_first", outstanding, 3);
        push_id(6'h2A);
        tick();
        chk("b2b_id", resp_id, 6'h2A);
        chk("cnt_after_pop1", outstanding, 2);
        chk("unsat_trans_gnt", trans_gnt, 1);
        push_id(6'h3F);
        tick();
        synch_req = 1'b0;
        chk("cnt_after_pop2", outstanding, 1);
        tick();
        chk("cnt_after_pop3", outstanding, 0);
        chk("busy_fall", busy, 0);
        chk("drained_valid", resp_valid, 0);

        // Underflow pop: count holds at zero
        push_id(6'h11);
        tick();
        synch_req = 1'b0;
        tick();
        chk("uflow_cnt", outstanding, 0);
        chk("uflow_err", err, ERR_EXP);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("err_cleared", err, 0);

        // Fill the queue with ready low; the fifth event is refused
        resp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            synch_req = 1'b1;
            synch_id  = IW'(i);
            if (i <= 4) exp_q.push_back(IW'(i));
            tick();
            if (i == 4) chk("full_gnt", synch_gnt, 0);
        end
        synch_req = 1'b0;
        chk("full_hold_gnt", synch_gnt, 0);
        chk("full_head", resp_id, 1);
        chk("full_err", err, ERR_EXP);
        tick();
        chk("stall_id", resp_id, 1);
        resp_ready = 1'b1;
        tick();
        chk("gnt_return", synch_gnt, 1);
        tick(); tick(); tick();
        chk("full_drained", resp_valid, 0);

        // Simultaneous push/pop at occupancy 2 and trans/pop at count 2, across pointer wrap
        resp_ready = 1'b0;
        trans_req  = 1'b1;
        push_id(6'h0A);
        tick();
        push_id(6'h0B);
        tick();
        chk("pp_cnt_start", outstanding, 2);
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_id(IW'(6'h20 + i));
            tick();
            chk("pp_cnt_hold", outstanding, 2);
        end
        chk("pp_head", resp_id, 6'h22);
        trans_req  = 1'b0;
        resp_ready = 1'b0;
        push_id(6'h30);
        tick();
        chk("pp_occ3_gnt", synch_gnt, 1);
        push_id(6'h31);
        tick();
        synch_req = 1'b0;
        chk("pp_occ4_gnt", synch_gnt, 0);
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("pp_drain", exp_q.size(), 0);
        chk("pp_cnt_end", outstanding, 0);

        // Reset mid-operation discards queued responses and the count
        resp_ready = 1'b0;
        trans_req  = 1'b1;
        tick(); tick(); tick();
        trans_req = 1'b0;
        push_id(6'h15);
        tick();
        push_id(6'h16);
        tick();
        synch_req = 1'b0;
        chk("pre_rst_cnt", outstanding, 3);
        chk("pre_rst_valid", resp_valid, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_lo_synch_gnt", synch_gnt, 0);
        chk("rst_lo_trans_gnt", trans_gnt, 0);
        tick();
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_cnt", outstanding, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_busy", busy, 0);
        resp_ready = 1'b1;
        tick();
        chk("mid_rst_gnt_hold", synch_gnt, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", resp_valid, 0);
        chk("post_rst_synch_gnt", synch_gnt, 1);
        chk("post_rst_trans_gnt", trans_gnt, 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
